reg_dst_mux: RTL and testbench

//   Register-destination select for the CPU decode/execute path.

---
 rtl/reg_dst_pkg.sv | 11 +
 rtl/reg_dst_mux_sel.sv | 31 +++
 rtl/reg_dst_mux.sv | 63 ++++++
 tb/tb_reg_dst_mux.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/reg_dst_pkg.sv
// Shared select codes for the write-back register destination mux.
package reg_dst_pkg;

  typedef logic [1:0] regdst_sel_t;

  localparam regdst_sel_t REGDST_RT   = 2'b00;
  localparam regdst_sel_t REGDST_RD   = 2'b01;
  localparam regdst_sel_t REGDST_RA   = 2'b10;
  localparam regdst_sel_t REGDST_RSVD = 2'b11;

endpackage

// File: rtl/reg_dst_mux_sel.sv
// Combinational 3:1 destination mux; the reserved code yields zero and raises err.
module reg_dst_mux_sel
  import reg_dst_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  regdst_sel_t      sel,
  output logic [WIDTH-1:0] out_comb,
  output logic             err
);

  always_comb begin
    out_comb = '0;
    err      = 1'b0;
    case (sel)
      REGDST_RT:   out_comb = a;
      REGDST_RD:   out_comb = b;
      REGDST_RA:   out_comb = c;
      REGDST_RSVD: err      = 1'b1;
      // Unknown select bits fall through with a zero index and no error.
      default: begin
        out_comb = '0;
        err      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_dst_mux.sv
// Register-destination select with an optional output pipeline register.
module reg_dst_mux
  import reg_dst_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       sel,
  input  logic             en,
  input  logic             flush,
  output logic [WIDTH-1:0] out_comb,
  output logic [WIDTH-1:0] out,
  output logic             sel_err
);

  logic err_comb;

  reg_dst_mux_sel #(
    .WIDTH(WIDTH)
  ) u_sel (
    .a        (a),
    .b        (b),
    .c        (c),
    .sel      (regdst_sel_t'(sel)),
    .out_comb (out_comb),
    .err      (err_comb)
  );

  generate
    if (REGISTERED) begin : g_registered
      logic [WIDTH-1:0] out_reg;
      logic             err_reg;

      // Flush outranks the load enable so a squashed slot never writes back.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_reg <= '0;
          err_reg <= 1'b0;
        end else if (flush) begin
          out_reg <= '0;
          err_reg <= 1'b0;
        end else if (en) begin
          out_reg <= out_comb;
          err_reg <= err_comb;
        end
      end

      assign out     = out_reg;
      assign sel_err = err_reg;
    end else begin : g_comb
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, en, flush};
      assign out         = out_comb;
      assign sel_err     = err_comb;
    end
  endgenerate

endmodule

// File: tb/tb_reg_dst_mux.sv
// Directed checks for reg_dst_mux: registered 4-bit instance and combinational 5-bit instance.
module tb_reg_dst_mux;

  logic       clk = 1'b0;
  logic       rst, en, flush;
  logic [3:0] a, b, c;
  logic [1:0] sel;
  logic [3:0] out_comb, out;
  logic       sel_err;

  logic       rst5, en5, flush5;
  logic [4:0] a5, b5, c5;
  logic [1:0] sel5;
  logic [4:0] out_comb5, out5;
  logic       sel_err5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_dst_mux #(.WIDTH(4), .REGISTERED(1'b1)) u_reg (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .sel(sel), .en(en), .flush(flush),
    .out_comb(out_comb), .out(out), .sel_err(sel_err)
  );

  reg_dst_mux #(.WIDTH(5), .REGISTERED(1'b0)) u_comb (
    .clk(clk), .rst(rst5), .a(a5), .b(b5), .c(c5), .sel(sel5), .en(en5), .flush(flush5),
    .out_comb(out_comb5), .out(out5), .sel_err(sel_err5)
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] a, b, c;
    logic [3:0] exp_out;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{2'b00, 4'h0, 4'h1, 4'h2, 4'h0, 1'b0};
    vecs[1] = '{2'b01, 4'h0, 4'h1, 4'h2, 4'h1, 1'b0};
    vecs[2] = '{2'b10, 4'h0, 4'h1, 4'h2, 4'h2, 1'b0};
    vecs[3] = '{2'b11, 4'h0, 4'h1, 4'h2, 4'h0, 1'b1};
    vecs[4] = '{2'b01, 4'h0, 4'h1, 4'h2, 4'h1, 1'b0};
    vecs[5] = '{2'b00, 4'hA, 4'h5, 4'hF, 4'hA, 1'b0};
    vecs[6] = '{2'b01, 4'hA, 4'h5, 4'hF, 4'h5, 1'b0};
    vecs[7] = '{2'b10, 4'hA, 4'h5, 4'hF, 4'hF, 1'b0};
    vecs[8] = '{2'b11, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1};
    vecs[9] = '{2'b10, 4'h3, 4'hC, 4'h7, 4'h7, 1'b0};

    rst = 1'b0; en = 1'b1; flush = 1'b0;
    a = 4'h0; b = 4'h1; c = 4'h2; sel = 2'b00;
    rst5 = 1'b0; en5 = 1'b1; flush5 = 1'b0;
    a5 = 5'h1F; b5 = 5'h0A; c5 = 5'h15; sel5 = 2'b00;

    #2 rst = 1'b1;
    #1;
    check("reset out", 32'(out), 32'h0);
    check("reset sel_err", 32'(sel_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table: comb result immediately, registered copy one edge later.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sel = vecs[i].sel; a = vecs[i].a; b = vecs[i].b; c = vecs[i].c;
      #1;
      check($sformatf("vec%0d out_comb", i), 32'(out_comb), 32'(vecs[i].exp_out));
      edge_step();
      check($sformatf("vec%0d out", i), 32'(out), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d sel_err", i), 32'(sel_err), 32'(vecs[i].exp_err));
    end

    // Stall: en=0 holds across three edges.
    @(negedge clk);
    a = 4'h0; b = 4'h1; c = 4'h2; sel = 2'b10;
    edge_step();
    check("stall preload", 32'(out), 32'h2);
    @(negedge clk);
    en = 1'b0; sel = 2'b01;
    for (int k = 0; k < 3; k++) begin
      edge_step();
      check($sformatf("stall hold %0d", k), 32'(out), 32'h2);
    end
    @(negedge clk);
    en = 1'b1;
    edge_step();
    check("stall release", 32'(out), 32'h1);

    // Flush outranks en even when the reserved code is selected.
    @(negedge clk);
    flush = 1'b1; sel = 2'b11;
    edge_step();
    check("flush out", 32'(out), 32'h0);
    check("flush sel_err", 32'(sel_err), 32'h0);
    @(negedge clk);
    flush = 1'b1; en = 1'b0; sel = 2'b01;
    edge_step();
    check("flush with en=0", 32'(out), 32'h0);
    @(negedge clk);
    flush = 1'b0; en = 1'b1;
    edge_step();
    check("flush reload", 32'(out), 32'h1);

    // Async reset between edges.
    @(negedge clk);
    sel = 2'b10;
    edge_step();
    check("pre-reset out", 32'(out), 32'h2);
    #2 rst = 1'b1;
    #1;
    check("async reset out", 32'(out), 32'h0);
    for (int k = 0; k < 2; k++) begin
      edge_step();
      check($sformatf("reset hold %0d", k), 32'(out), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    edge_step();
    check("post-reset load", 32'(out), 32'h2);

    // Combinational instance: clk, rst, en, flush have no effect.
    #1;
    check("comb out 1F", 32'(out5), 32'h1F);
    check("comb sel_err", 32'(sel_err5), 32'h0);
    rst5 = 1'b1; en5 = 1'b0; flush5 = 1'b1;
    edge_step();
    check("comb ignore ctrl", 32'(out5), 32'h1F);
    rst5 = 1'b0; flush5 = 1'b0;
    sel5 = 2'b10;
    #1;
    check("comb sel c", 32'(out5), 32'h15);
    sel5 = 2'b11;
    #1;
    check("comb rsvd out", 32'(out5), 32'h0);
    check("comb rsvd err", 32'(sel_err5), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
